// File: rtl/stream_word_packer_pkg.sv
// Shared types and helpers for stream_word_packer: lane-index width and default wide-word payload.
package stream_word_packer_pkg;

  localparam int unsigned InWidth  = 8;
  localparam int unsigned Ratio    = 4;
  localparam int unsigned OutWidth = InWidth * Ratio;

  // A lane counter needs at least one bit, even when RATIO is 1.
  function automatic int unsigned lane_idx_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  typedef struct packed {
    logic [OutWidth-1:0] data;
    logic [Ratio-1:0]    strb;
    logic                last;
  } word_t;

endpackage

// File: rtl/stream_word_packer_idle_timer.sv
// Saturating idle counter: counts enabled cycles up to LIMIT, cleared on demand.
module stream_word_packer_idle_timer
  import stream_word_packer_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(LIMIT);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != Limit)) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == Limit);

endmodule

// File: rtl/stream_word_packer.sv
// Packs RATIO narrow beats (lane 0 first) into one wide word with strobe and last.
// Optional partial-word timeout flush under STREAM_WORD_PACKER_TIMEOUT_EN.
module stream_word_packer
  import stream_word_packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = 8,
  parameter int unsigned RATIO          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [IN_WIDTH-1:0]          in_data_i,
  input  logic                         in_last_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [IN_WIDTH*RATIO-1:0]    out_data_o,
  output logic [RATIO-1:0]             out_strb_o,
  output logic                         out_last_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);

  localparam int unsigned CntW = lane_idx_width(RATIO);
  localparam int unsigned OutW = IN_WIDTH * RATIO;
  localparam logic [CntW-1:0] LastLane = CntW'(RATIO - 1);

  if ((IN_WIDTH < 1) || (RATIO < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("stream_word_packer: IN_WIDTH, RATIO and TIMEOUT_CYCLES must be >= 1");
  end

  typedef struct packed {
    logic [OutW-1:0]  data;
    logic [RATIO-1:0] strb;
    logic             last;
  } out_word_t;

  out_word_t        word_q, word_d;
  logic             out_valid_q, out_valid_d;
  logic [OutW-1:0]  acc_data_q, acc_data_d;
  logic [RATIO-1:0] acc_strb_q, acc_strb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             out_fire;
  logic             complete;
  logic             flush;
  logic [OutW-1:0]  merged_data;
  logic [RATIO-1:0] merged_strb;

  // Ready depends only on the output side so upstream never sees a valid->ready path.
  assign in_ready_o  = ~rst_i & (~out_valid_q | out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_q & out_ready_i;
  assign complete    = accept & ((cnt_q == LastLane) | in_last_i);

  // Unfilled lanes of the accumulator are always zero, so OR-merging is safe.
  assign merged_data = acc_data_q | (OutW'(in_data_i) << (32'(cnt_q) * IN_WIDTH));
  assign merged_strb = acc_strb_q | (RATIO'(1) << cnt_q);

`ifdef STREAM_WORD_PACKER_TIMEOUT_EN
  logic idle_expired;

  stream_word_packer_idle_timer #(
    .LIMIT     (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (accept | flush),
    .enable_i  (cnt_q != '0),
    .expired_o (idle_expired)
  );

  // An accepted beat always wins over the timeout flush.
  assign flush = idle_expired & (cnt_q != '0) & ~accept & (~out_valid_q | out_ready_i);
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    word_d      = word_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    cnt_d       = cnt_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (complete) begin
      out_valid_d = 1'b1;
      word_d.data = merged_data;
      word_d.strb = merged_strb;
      word_d.last = in_last_i;
      acc_data_d  = '0;
      acc_strb_d  = '0;
      cnt_d       = '0;
    end else if (flush) begin
      out_valid_d = 1'b1;
      word_d.data = acc_data_q;
      word_d.strb = acc_strb_q;
      word_d.last = 1'b0;
      acc_data_d  = '0;
      acc_strb_d  = '0;
      cnt_d       = '0;
    end else if (accept) begin
      acc_data_d  = merged_data;
      acc_strb_d  = merged_strb;
      cnt_d       = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      word_q      <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      word_q      <= word_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = word_q.data;
  assign out_strb_o  = word_q.strb;
  assign out_last_o  = word_q.last;
  assign busy_o      = (cnt_q != '0) | out_valid_q;

endmodule

// File: tb/tb_stream_word_packer.sv
// Self-checking bench for stream_word_packer: directed steps plus random traffic vs a packing model.
module tb_stream_word_packer;

  localparam int unsigned IW  = 8;
  localparam int unsigned R   = 4;
  localparam int unsigned OW  = IW * R;
  localparam int unsigned TMO = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [IW-1:0] in_data_i;
  logic          in_last_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [OW-1:0] out_data_o;
  logic [R-1:0]  out_strb_o;
  logic          out_last_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          busy_o;

  stream_word_packer #(
    .IN_WIDTH       (IW),
    .RATIO          (R),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .out_last_o  (out_last_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [OW-1:0] d;
    logic [R-1:0]  s;
    logic          l;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;

  // Reference model: words awaiting delivery plus the partial word being gathered.
  exp_t          exp_q[$];
  logic [OW-1:0] m_data = '0;
  logic [R-1:0]  m_strb = '0;
  int            m_n    = 0;
  int            m_idle = 0;
  bit            hold_pending = 0;
  exp_t          held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_data       = '0;
    m_strb       = '0;
    m_n          = 0;
    m_idle       = 0;
    hold_pending = 0;
  endtask

  // One clock cycle: drive, check against the model, advance the model, cross the edge.
  task automatic step(input bit rst, input bit v, input logic [IW-1:0] d, input bit l, input bit rdy);
    bit   acc;
    bit   flush;
    exp_t front;
    rst_i       = rst;
    in_valid_i  = v;
    in_data_i   = d;
    in_last_i   = l;
    out_ready_i = rdy;
    #1;
    chk("out_valid", out_valid_o, 64'(exp_q.size() != 0));
    chk("busy", busy_o, 64'((m_n != 0) || (exp_q.size() != 0)));
    chk("in_ready", in_ready_o, 64'(!rst && ((exp_q.size() == 0) || rdy)));
    if (hold_pending) begin
      chk("hold_data", out_data_o, 64'(held.d));
      chk("hold_strb", out_strb_o, 64'(held.s));
      chk("hold_last", out_last_o, 64'(held.l));
    end
    if (exp_q.size() != 0 && out_valid_o === 1'b1) begin
      front = exp_q[0];
      chk("word_data", out_data_o, 64'(front.d));
      chk("word_strb", out_strb_o, 64'(front.s));
      chk("word_last", out_last_o, 64'(front.l));
    end
    if (rst) begin
      model_clear();
    end else begin
      acc = v && ((exp_q.size() == 0) || rdy);
      hold_pending = (exp_q.size() != 0) && !rdy;
      if (hold_pending) held = exp_q[0];
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      flush = 0;
`ifdef STREAM_WORD_PACKER_TIMEOUT_EN
      flush = !acc && (m_n != 0) && (m_idle >= int'(TMO)) && (exp_q.size() == 0);
`endif
      if (acc) begin
        m_data[m_n*IW +: IW] = d;
        m_strb[m_n]          = 1'b1;
        m_n++;
        if (m_n == int'(R) || l) begin
          exp_q.push_back('{d: m_data, s: m_strb, l: l});
          m_data = '0;
          m_strb = '0;
          m_n    = 0;
        end
        m_idle = 0;
      end else if (flush) begin
        exp_q.push_back('{d: m_data, s: m_strb, l: 1'b0});
        m_data = '0;
        m_strb = '0;
        m_n    = 0;
        m_idle = 0;
      end else if (m_n != 0 && m_idle < int'(TMO)) begin
        m_idle++;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset with valid asserted: nothing accepted, nothing emitted.
    rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'h5A; in_last_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) step(1, 1, 8'h5A, 1, 1);
    chk("rst_data", out_data_o, 64'h0);
    chk("rst_strb", out_strb_o, 64'h0);
    chk("rst_last", out_last_o, 64'h0);
    chk("rst_valid", out_valid_o, 64'h0);

    // Full word, visible one cycle after the completing beat.
    step(0, 1, 8'h11, 0, 1);
    step(0, 1, 8'h22, 0, 1);
    step(0, 1, 8'h33, 0, 1);
    step(0, 1, 8'h44, 1, 1);
    chk("full_valid", out_valid_o, 64'h1);
    chk("full_data", out_data_o, 64'h44332211);
    chk("full_strb", out_strb_o, 64'hF);
    chk("full_last", out_last_o, 64'h1);

    // Short packet, then next packet restarts at lane 0.
    step(0, 1, 8'hAA, 0, 1);
    step(0, 1, 8'hBB, 1, 1);
    chk("short_data", out_data_o, 64'h0000BBAA);
    chk("short_strb", out_strb_o, 64'h3);
    chk("short_last", out_last_o, 64'h1);
    step(0, 1, 8'h01, 0, 1);
    step(0, 1, 8'h02, 0, 1);
    step(0, 1, 8'h03, 0, 1);
    step(0, 1, 8'h04, 0, 1);
    chk("lane0_data", out_data_o, 64'h04030201);
    chk("lane0_last", out_last_o, 64'h0);

    // Backpressure: held word stays stable and input stalls.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'hEE, 0, 0);
      chk("bp_in_ready", in_ready_o, 64'h0);
    end
    chk("bp_data", out_data_o, 64'h04030201);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'(8'h80 + i), 0, 1);
      if (i == 3) chk("bp_word0", out_data_o, 64'h83828180);
    end
    chk("bp_word1", out_data_o, 64'h87868584);
    chk("bp_word1_strb", out_strb_o, 64'hF);

    // Reset mid-word discards the partial beats.
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'hD1, 0, 1);
    step(0, 1, 8'hD2, 0, 1);
    step(1, 1, 8'hD3, 0, 1);
    step(0, 1, 8'hC1, 0, 1);
    step(0, 1, 8'hC2, 0, 1);
    step(0, 1, 8'hC3, 0, 1);
    step(0, 1, 8'hC4, 0, 1);
    chk("rstmid_data", out_data_o, 64'hC4C3C2C1);
    chk("rstmid_strb", out_strb_o, 64'hF);
    step(0, 0, 8'h00, 0, 1);

`ifdef STREAM_WORD_PACKER_TIMEOUT_EN
    // Idle partial word flushes after the timeout window.
    step(0, 1, 8'h31, 0, 1);
    step(0, 1, 8'h32, 0, 1);
    step(0, 1, 8'h33, 0, 1);
    for (int k = 1; k <= 17; k++) begin
      step(0, 0, 8'h00, 0, 1);
      if (k <= 16) chk("tmo_wait_valid", out_valid_o, 64'h0);
    end
    chk("tmo_valid", out_valid_o, 64'h1);
    chk("tmo_data", out_data_o, 64'h00333231);
    chk("tmo_strb", out_strb_o, 64'h7);
    chk("tmo_last", out_last_o, 64'h0);
    step(0, 0, 8'h00, 0, 1);
    // A beat arriving as the timer expires completes the word instead.
    step(0, 1, 8'h41, 0, 1);
    step(0, 1, 8'h42, 0, 1);
    step(0, 1, 8'h43, 0, 1);
    for (int k = 1; k <= 16; k++) step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h44, 0, 1);
    chk("tmo_race_data", out_data_o, 64'h44434241);
    chk("tmo_race_strb", out_strb_o, 64'hF);
    step(0, 0, 8'h00, 0, 1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63, 0) == 0),
           ($urandom_range(99, 0) < 70),
           8'($urandom),
           ($urandom_range(99, 0) < 15),
           ($urandom_range(99, 0) < 60));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 1);
    chk("drain_valid", out_valid_o, 64'h0);
    chk("drain_queue", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
